// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner and its event FIFO.
package keypad_pkg;

    typedef enum logic [1:0] {
        SETTLE,
        CAPTURE,
        EVAL,
        ADVANCE
    } scan_state_t;

    // Wide enough for the largest keypad (8x8); narrower keypads zero-extend the code.
    localparam int EVT_CODE_W = 6;

    typedef struct packed {
        logic                  press;
        logic [EVT_CODE_W-1:0] code;
    } key_evt_t;

    function automatic int key_width(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// Press/release event stream between the keypad scanner (master) and its consumer (slave).
interface keypad_matrix_scanner_if #(
    parameter int KW = 4
) ();

    logic          evt_valid;
    logic          evt_ready;
    logic [KW-1:0] evt_code;
    logic          evt_press;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_press,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_press,
        output evt_ready
    );

endinterface

// File: rtl/keypad_evt_fifo.sv
// Small synchronous FIFO holding key events; extra pointer bit separates full from empty.
module keypad_evt_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head  = mem_q[rptr_q[AW-1:0]];

    // When full, the slot being written is exactly the one being popped this cycle.
    always_comb begin
        rd_en  = pop && !empty;
        wr_en  = push && (!full || rd_en);
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) begin
            wptr_d = wptr_q + (AW+1)'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Column-scanning keypad reader with per-key debounce, a level bitmap of keys,
// and a press/release event FIFO behind a valid/ready handshake.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 300_000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ROWS-1:0]      row,
    output logic [COLS-1:0]      col,
    output logic [ROWS*COLS-1:0] keys,
    keypad_matrix_scanner_if.master evt,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam int NK    = ROWS * COLS;
    localparam int KW    = key_width(ROWS, COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int CIW   = $clog2(COLS);
    localparam int DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    scan_state_t     state_q, state_d;
    logic [ROWS-1:0] row_meta_q, row_meta_d;
    logic [ROWS-1:0] row_sync_q, row_sync_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CIW-1:0]  col_idx_q, col_idx_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [ROWS-1:0] sample_q, sample_d;
    logic [NK-1:0]   keys_q, keys_d;
    logic [COLS-1:0] col_q, col_d;
    logic            overflow_q, overflow_d;
    logic [CNT_W-1:0] cnt_q [NK];
    logic [CNT_W-1:0] cnt_d [NK];

    logic [KW-1:0]   key_idx;
    logic            push;
    key_evt_t        push_evt;
    key_evt_t        head_evt;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    always_comb begin
        row_meta_d = row;
        row_sync_d = row_meta_q;
        state_d    = state_q;
        div_d      = div_q;
        col_idx_d  = col_idx_q;
        row_idx_d  = row_idx_q;
        sample_d   = sample_q;
        keys_d     = keys_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_evt   = '0;
        key_idx    = KW'(int'(row_idx_q) * COLS + int'(col_idx_q));

        unique case (state_q)
            SETTLE: begin
                if (div_q == DW'(SCAN_DIV - 1)) begin
                    div_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            CAPTURE: begin
                sample_d = ~row_sync_q;
                state_d  = EVAL;
            end
            EVAL: begin
                // A key flips only after DEBOUNCE_SCANS consecutive disagreeing samples.
                if (sample_q[row_idx_q] == keys_q[key_idx]) begin
                    cnt_d[key_idx] = '0;
                end else if (cnt_q[key_idx] == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                    keys_d[key_idx] = ~keys_q[key_idx];
                    cnt_d[key_idx]  = '0;
                    push            = 1'b1;
                    push_evt.press  = ~keys_q[key_idx];
                    push_evt.code   = EVT_CODE_W'(key_idx);
                end else begin
                    cnt_d[key_idx] = cnt_q[key_idx] + CNT_W'(1);
                end
                if (row_idx_q == RW'(ROWS - 1)) begin
                    row_idx_d = '0;
                    state_d   = ADVANCE;
                end else begin
                    row_idx_d = row_idx_q + RW'(1);
                end
            end
            ADVANCE: begin
                col_idx_d = (col_idx_q == CIW'(COLS - 1)) ? '0 : col_idx_q + CIW'(1);
                state_d   = SETTLE;
            end
            default: state_d = SETTLE;
        endcase

        col_d = ~(COLS'(1) << col_idx_d);

        // A dropped event wins over a clear arriving in the same cycle.
        if (ovf_clr) begin
            overflow_d = 1'b0;
        end
        if (push && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q <= '1;
            row_sync_q <= '1;
            state_q    <= SETTLE;
            div_q      <= '0;
            col_idx_q  <= '0;
            row_idx_q  <= '0;
            sample_q   <= '0;
            keys_q     <= '0;
            col_q      <= '1;
            overflow_q <= 1'b0;
            cnt_q      <= '{default: '0};
        end else begin
            row_meta_q <= row_meta_d;
            row_sync_q <= row_sync_d;
            state_q    <= state_d;
            div_q      <= div_d;
            col_idx_q  <= col_idx_d;
            row_idx_q  <= row_idx_d;
            sample_q   <= sample_d;
            keys_q     <= keys_d;
            col_q      <= col_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
        end
    end

    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(key_evt_t))
    ) u_evt_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_evt),
        .full      (fifo_full),
        .pop       (pop),
        .empty     (fifo_empty),
        .head      (head_evt)
    );

    assign pop           = !fifo_empty && evt.evt_ready;
    assign evt.evt_valid = !fifo_empty;
    assign evt.evt_code  = fifo_empty ? '0 : KW'(head_evt.code);
    assign evt.evt_press = fifo_empty ? 1'b0 : head_evt.press;

    assign col      = col_q;
    assign keys     = keys_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner: 4x4 matrix, 10-cycle slots, 40-cycle frames.
module tb_keypad_matrix_scanner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] keys;
    logic        overflow;
    logic        ovf_clr = 1'b0;
    logic [15:0] phys = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;

    keypad_matrix_scanner_if #(.KW(4)) evt_if ();

    keypad_matrix_scanner #(
        .ROWS           (4),
        .COLS           (4),
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (2),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .row      (row),
        .col      (col),
        .keys     (keys),
        .evt      (evt_if),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    // Physical matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (phys[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic goTo(input int target);
        while (cyc < target) begin
            tick();
        end
    endtask

    task automatic applyStimulus(input logic [15:0] pressed, input logic ready);
        phys             = pressed;
        evt_if.evt_ready = ready;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        applyStimulus(16'h0000, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("rst_col", 32'(col), 32'hF);
        checkOutput("rst_keys", 32'(keys), 32'h0);
        checkOutput("rst_valid", 32'(evt_if.evt_valid), 32'h0);
        checkOutput("rst_code", 32'(evt_if.evt_code), 32'h0);
        checkOutput("rst_press", 32'(evt_if.evt_press), 32'h0);
        checkOutput("rst_ovf", 32'(overflow), 32'h0);
        rst_n = 1'b1;
        cyc   = 0;

        // Column walk and slot length
        goTo(1);   checkOutput("col_first", 32'(col), 32'hE);
        goTo(9);   checkOutput("col_slot0_end", 32'(col), 32'hE);
        goTo(10);  checkOutput("col_slot1_start", 32'(col), 32'hD);
        goTo(25);  checkOutput("col_slot2", 32'(col), 32'hB);
        goTo(35);  checkOutput("col_slot3", 32'(col), 32'h7);
        goTo(39);  checkOutput("idle_valid", 32'(evt_if.evt_valid), 32'h0);
        checkOutput("idle_keys", 32'(keys), 32'h0);
        goTo(40);  checkOutput("col_wrap", 32'(col), 32'hE);

        // Key 9 (r2,c1) press and release
        goTo(41);  applyStimulus(16'h0200, 1'b1);
        goTo(97);  checkOutput("k9_before", 32'(keys), 32'h0);
        goTo(98);  checkOutput("k9_keys", 32'(keys), 32'h0200);
        checkOutput("k9_valid", 32'(evt_if.evt_valid), 32'h1);
        checkOutput("k9_code", 32'(evt_if.evt_code), 32'd9);
        checkOutput("k9_press", 32'(evt_if.evt_press), 32'h1);
        goTo(99);  checkOutput("k9_popped", 32'(evt_if.evt_valid), 32'h0);
        goTo(138); checkOutput("k9_no_repeat", 32'(evt_if.evt_valid), 32'h0);
        checkOutput("k9_held", 32'(keys), 32'h0200);
        goTo(140); applyStimulus(16'h0000, 1'b1);
        goTo(217); checkOutput("k9_rel_before", 32'(keys), 32'h0200);
        goTo(218); checkOutput("k9_rel_keys", 32'(keys), 32'h0);
        checkOutput("k9_rel_valid", 32'(evt_if.evt_valid), 32'h1);
        checkOutput("k9_rel_code", 32'(evt_if.evt_code), 32'd9);
        checkOutput("k9_rel_press", 32'(evt_if.evt_press), 32'h0);

        // Two separated single-sample glitches on key 5
        goTo(240); applyStimulus(16'h0020, 1'b1);
        goTo(260); applyStimulus(16'h0000, 1'b1);
        goTo(297); checkOutput("g5_keys", 32'(keys), 32'h0);
        checkOutput("g5_valid", 32'(evt_if.evt_valid), 32'h0);
        goTo(320); applyStimulus(16'h0020, 1'b1);
        goTo(337); checkOutput("g5_keys2", 32'(keys), 32'h0);
        checkOutput("g5_valid2", 32'(evt_if.evt_valid), 32'h0);
        goTo(340); applyStimulus(16'h0000, 1'b1);

        // Column 0 burst fills the FIFO, then key 1 overflows it
        goTo(380); applyStimulus(16'h1111, 1'b0);
        goTo(449); applyStimulus(16'h1113, 1'b0);
        checkOutput("burst_keys", 32'(keys), 32'h1111);
        checkOutput("burst_valid", 32'(evt_if.evt_valid), 32'h1);
        checkOutput("burst_code", 32'(evt_if.evt_code), 32'd0);
        goTo(495); checkOutput("ovf_before", 32'(overflow), 32'h0);
        goTo(496); checkOutput("ovf_set", 32'(overflow), 32'h1);
        checkOutput("ovf_keys", 32'(keys), 32'h1113);
        checkOutput("ovf_head_stable", 32'(evt_if.evt_code), 32'd0);
        goTo(500); ovf_clr = 1'b1;
        goTo(501); ovf_clr = 1'b0;
        checkOutput("ovf_clr", 32'(overflow), 32'h0);
        goTo(505); checkOutput("drain0", 32'(evt_if.evt_code), 32'd0);
        applyStimulus(16'h1113, 1'b1);
        goTo(506); checkOutput("drain1", 32'(evt_if.evt_code), 32'd4);
        goTo(507); checkOutput("drain2", 32'(evt_if.evt_code), 32'd8);
        goTo(508); checkOutput("drain3", 32'(evt_if.evt_code), 32'd12);
        checkOutput("drain3_press", 32'(evt_if.evt_press), 32'h1);
        goTo(509); checkOutput("drain_empty", 32'(evt_if.evt_valid), 32'h0);
        applyStimulus(16'h1113, 1'b0);

        // Releases fill the FIFO; fifth event pushed while the head is popped
        goTo(510); applyStimulus(16'h0000, 1'b0);
        goTo(575); checkOutput("full_head", 32'(evt_if.evt_code), 32'd0);
        checkOutput("full_press", 32'(evt_if.evt_press), 32'h0);
        applyStimulus(16'h0000, 1'b1);
        goTo(576); checkOutput("pp_code1", 32'(evt_if.evt_code), 32'd4);
        checkOutput("pp_keys", 32'(keys), 32'h0);
        goTo(577); checkOutput("pp_code2", 32'(evt_if.evt_code), 32'd8);
        goTo(578); checkOutput("pp_code3", 32'(evt_if.evt_code), 32'd12);
        goTo(579); checkOutput("pp_code4", 32'(evt_if.evt_code), 32'd1);
        checkOutput("pp_press4", 32'(evt_if.evt_press), 32'h0);
        goTo(580); checkOutput("pp_empty", 32'(evt_if.evt_valid), 32'h0);
        checkOutput("pp_no_ovf", 32'(overflow), 32'h0);

        // Reset in the middle of EVAL with two events queued
        applyStimulus(16'h0011, 1'b0);
        goTo(647); checkOutput("pre_rst_valid", 32'(evt_if.evt_valid), 32'h1);
        checkOutput("pre_rst_keys", 32'(keys), 32'h0011);
        rst_n = 1'b0;
        goTo(648); checkOutput("mid_rst_col", 32'(col), 32'hF);
        checkOutput("mid_rst_valid", 32'(evt_if.evt_valid), 32'h0);
        checkOutput("mid_rst_keys", 32'(keys), 32'h0);
        goTo(649); rst_n = 1'b1;
        cyc = 0;
        goTo(1);   checkOutput("rst2_col0", 32'(col), 32'hE);
        goTo(10);  checkOutput("rst2_col1", 32'(col), 32'hD);
        goTo(45);  checkOutput("rst2_fifo_clear", 32'(evt_if.evt_valid), 32'h0);
        goTo(46);  checkOutput("rst2_valid", 32'(evt_if.evt_valid), 32'h1);
        checkOutput("rst2_code", 32'(evt_if.evt_code), 32'd0);
        checkOutput("rst2_keys_a", 32'(keys), 32'h0001);
        goTo(47);  checkOutput("rst2_keys_b", 32'(keys), 32'h0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

Parametrised matrix-keypad scanner replacing the fixed 4x4 keypad block between the board row/col pins and the game logic. It drives one column at a time, debounces every key individually, and presents a level bitmap of debounced keys. It also queues press/release events in a small FIFO with a valid/ready handshake, so the consumer never misses an edge.

## Interface
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- SCAN_DIV, 300_000, settle cycles per column slot; must be >= ROWS+2
- DEBOUNCE_SCANS, 3, consecutive disagreeing samples needed to flip a key's stable state (1..15)
- FIFO_DEPTH, 8, event FIFO entries (power of two, >= 2)
- KW (derived), $clog2(ROWS*COLS), key index width

- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- row  in  ROWS  row sense lines, active-low (pulled up externally)
- col  out  COLS  column drive, active-low, at most one bit low
- keys  out  ROWS*COLS  debounced key levels, bit r*COLS+c, 1 = pressed
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts head this cycle
- evt_code  out  KW  key index of head event
- evt_press  out  1  1 = press, 0 = release
- overflow  out  1  sticky: an event was dropped
- ovf_clr  in  1  clears overflow

## Operation
- row passes through a 2-flop synchronizer before use; raw sample = ~row_sync.
- FSM states: SETTLE, CAPTURE, EVAL, ADVANCE.
  - SETTLE: col slot c driven low. Counts SCAN_DIV cycles, then goes to CAPTURE.
  - CAPTURE: latch the raw sample into the sample register (1 cycle), then go to EVAL.
  - EVAL: one row r per cycle, r = 0..ROWS-1, for key k = r*COLS+c.
    - If sample[r] == keys[k], clear cnt[k].
    - Otherwise increment cnt[k]. When it reaches DEBOUNCE_SCANS, toggle keys[k], clear cnt[k], and push event {k, new level}.
    - After r = ROWS-1, go to ADVANCE.
  - ADVANCE: c = (c == COLS-1) ? 0 : c+1; col updates this cycle; return to SETTLE.
- col stays constant from SETTLE through EVAL.
- Debounce counters are per key, width $clog2(DEBOUNCE_SCANS+1), and saturate-free (they are cleared on reaching the threshold).
- FIFO behaviour:
  - Push accepted when not full, or when full and a pop occurs in the same cycle.
  - A rejected push sets overflow. keys still updates; only the event is lost.
  - Pop occurs when evt_valid & evt_ready.
  - Simultaneous push and pop on empty: the pushed entry becomes the head the next cycle (no bypass).
- overflow: set-dominant over ovf_clr in the same cycle; otherwise ovf_clr clears it.
- Reset mid-scan:
  - Everything returns to reset values immediately.
  - FIFO contents are discarded.
  - The scan restarts at column 0 after release.

## Timing
- Reset values:
  - col = all ones.
  - keys = 0, evt_valid = 0, evt_code = 0, evt_press = 0, overflow = 0.
  - FSM in SETTLE, c = 0, all counters 0.
- First cycle after rst_n rises: col[0] low.
- Column slot length = SCAN_DIV + 1 + ROWS + 1 cycles. Full frame = COLS × slot.
- Pin-to-sample latency: 2 cycles of synchronizer; the value captured is the one present at the last SETTLE cycle minus 2.
- keys[k] and the FIFO write for key k happen in the same EVAL cycle. evt_valid rises 1 cycle later if the FIFO was empty.
- A press is reported DEBOUNCE_SCANS frames after it becomes stable.
- Max push rate is 1 event/cycle; a single slot can produce at most ROWS events.
- evt_code/evt_press are stable while evt_valid=1 and evt_ready=0.

## Structure
- Package keypad_pkg:
  - scan_state_t enum {SETTLE, CAPTURE, EVAL, ADVANCE}.
  - Event struct {press, code}.
  - Width helper function for KW.
- Sub-module keypad_evt_fifo: synchronous FIFO.
  - Parameters DEPTH and WIDTH.
  - Ports: push, full, pop, empty, head data.
  - Pointers are $clog2(DEPTH)+1 bits to separate full from empty.
- Top of scanner: synchronizer, FSM, divider counter, debounce counter array, keys register, overflow flag.

## Test plan
Run with ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_SCANS=2, FIFO_DEPTH=4.
- Reset, no keys: col cycles 1110,1101,1011,0111 with 10-cycle slots; keys=0; evt_valid stays 0.
- Hold key r=2,c=1 for 3 frames, evt_ready=1 -> keys[9]=1 after 2nd sample in slot c=1; one event code=9 press=1; no repeat. Release -> code=9 press=0 after 2 samples.
- Single-frame glitch on key 5 (one sample pressed) -> cnt clears; keys[5]=0; no event.
- evt_ready=0; press all four keys of column 0 simultaneously, then key 1 -> 4 events queued (codes 0,4,8,12); 5th dropped; overflow=1. Pulse ovf_clr -> overflow=0; draining yields codes 0,4,8,12 in order.
- FIFO full with evt_ready=1 in the cycle a new event is pushed -> push accepted; no overflow; order preserved.
- Assert rst_n low mid-EVAL with 2 queued events -> next cycle: col=1111, evt_valid=0, keys=0; after release the scan resumes at column 0.
